// File: rtl/mem_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_bus_arbiter_if
// Function : Request/response channel between one bus master and the arbiter.
// Revision : 1.0  initial release
// ============================================================================
interface mem_bus_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ack;
  logic [DATA_W-1:0] rdata;
  logic              err;

  modport master (output req, we, addr, wdata, input ack, rdata, err);
  modport slave  (input req, we, addr, wdata, output ack, rdata, err);
endinterface
`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_bus_arbiter
// Function : Round-robin CPU/DMA arbiter for the shared ROM+RAM bus with
//            address decode, strobe sequencing and fixed read latency.
// Revision : 1.0  initial release
// ============================================================================
module mem_bus_arbiter #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 8,
  parameter int ROM_SIZE = 256,
  parameter int RAM_SIZE = 256,
  parameter int RD_LAT   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_bus_arbiter_if.slave  m0_if,
  mem_bus_arbiter_if.slave  m1_if,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_rd_o,
  output logic              mem_wr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              rom_sel_o,
  output logic              ram_sel_o,
  output logic              busy_o,
  output logic              grant_id_o
);

  localparam int              CNT_W      = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(RD_LAT - 1);
  // One extra bit so the region limits never wrap at the top of the space.
  localparam logic [ADDR_W:0] C_ROM_END  = (ADDR_W + 1)'(ROM_SIZE);
  localparam logic [ADDR_W:0] C_RAM_END  = (ADDR_W + 1)'(ROM_SIZE + RAM_SIZE);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t            state_q;
  logic              last_grant_q;
  logic              gid_q;
  logic              busy_q;
  logic              we_q;
  logic              err_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              mem_rd_q;
  logic              mem_wr_q;
  logic              rom_sel_q;
  logic              ram_sel_q;
  logic [1:0]        ack_q;
  logic [DATA_W-1:0] rdata_q;
  logic              rsp_err_q;

  logic              req_any_d;
  logic              gnt_d;
  logic              we_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] wdata_d;
  logic              is_rom_d;
  logic              is_ram_d;
  logic              err_d;
  logic [ADDR_W-1:0] offset_d;

  // Grant selection and decode of the candidate request, used only in IDLE.
  always_comb begin
    req_any_d = m0_if.req | m1_if.req;
    if (m0_if.req && m1_if.req) begin
      gnt_d = ~last_grant_q;
    end else begin
      gnt_d = m1_if.req;
    end
    we_d     = gnt_d ? m1_if.we    : m0_if.we;
    addr_d   = gnt_d ? m1_if.addr  : m0_if.addr;
    wdata_d  = gnt_d ? m1_if.wdata : m0_if.wdata;
    is_rom_d = ({1'b0, addr_d} < C_ROM_END);
    is_ram_d = !is_rom_d && ({1'b0, addr_d} < C_RAM_END);
    err_d    = (!is_rom_d && !is_ram_d) || (is_rom_d && we_d);
    offset_d = is_ram_d ? (addr_d - ADDR_W'(ROM_SIZE)) : addr_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      gid_q        <= 1'b0;
      busy_q       <= 1'b0;
      we_q         <= 1'b0;
      err_q        <= 1'b0;
      cnt_q        <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_rd_q     <= 1'b0;
      mem_wr_q     <= 1'b0;
      rom_sel_q    <= 1'b0;
      ram_sel_q    <= 1'b0;
      ack_q        <= 2'b00;
      rdata_q      <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      // Strobes and responses are single-cycle pulses.
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      rom_sel_q   <= 1'b0;
      ram_sel_q   <= 1'b0;
      ack_q       <= 2'b00;
      rdata_q     <= '0;
      rsp_err_q   <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (req_any_d) begin
            state_q      <= S_ADDR;
            gid_q        <= gnt_d;
            last_grant_q <= gnt_d;
            busy_q       <= 1'b1;
            we_q         <= we_d;
            err_q        <= err_d;
            if (!err_d) begin
              mem_addr_q  <= offset_d;
              mem_rd_q    <= !we_d;
              mem_wr_q    <= we_d;
              mem_wdata_q <= we_d ? wdata_d : '0;
              rom_sel_q   <= is_rom_d;
              ram_sel_q   <= is_ram_d;
            end
          end
        end

        S_ADDR: begin
          if (!we_q && !err_q) begin
            state_q <= S_WAIT;
            cnt_q   <= '0;
          end else begin
            state_q      <= S_DONE;
            ack_q[gid_q] <= 1'b1;
            rsp_err_q    <= err_q;
          end
        end

        S_WAIT: begin
          if (cnt_q == C_CNT_LAST) begin
            state_q      <= S_DONE;
            ack_q[gid_q] <= 1'b1;
            rdata_q      <= mem_rdata_i;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          gid_q   <= 1'b0;
        end

        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          gid_q   <= 1'b0;
        end
      endcase
    end
  end

  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign mem_rd_o    = mem_rd_q;
  assign mem_wr_o    = mem_wr_q;
  assign rom_sel_o   = rom_sel_q;
  assign ram_sel_o   = ram_sel_q;
  assign busy_o      = busy_q;
  assign grant_id_o  = gid_q;

  assign m0_if.ack   = ack_q[0];
  assign m0_if.rdata = ack_q[0] ? rdata_q : '0;
  assign m0_if.err   = ack_q[0] & rsp_err_q;
  assign m1_if.ack   = ack_q[1];
  assign m1_if.rdata = ack_q[1] ? rdata_q : '0;
  assign m1_if.err   = ack_q[1] & rsp_err_q;

endmodule
`default_nettype wire
